// File: rtl/bep_frame_capture_pkg.sv
// ---------------------------------------------------------------------------
// bep_frame_capture_pkg
// Shared definitions for the frame capture block that sits behind the serial
// frame decoder:
//   - REC_W and the bit offsets of each decoded field inside a 72-bit record
//   - FSM state encodings of the capture controller
//   - payload byte count and the tail-check helper function
// No ports (package).
// ---------------------------------------------------------------------------
package bep_frame_capture_pkg;

  localparam int REC_W         = 72;
  localparam int PAYLOAD_BYTES = 9;

  // Record layout: {thermostat_id, room_temp, set_temp, state}
  localparam int ID_LSB    = 40;
  localparam int ID_W      = 32;
  localparam int ROOM_LSB  = 24;
  localparam int ROOM_W    = 16;
  localparam int SET_LSB   = 8;
  localparam int SET_W     = 16;
  localparam int STATE_LSB = 0;
  localparam int STATE_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_COMMIT = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_WAIT   = 3'd4
  } fsm_state_e;

  typedef struct packed {
    logic [7:0] sum;
    logic [7:0] parity;
  } check_t;

  // Sum and XOR are order independent, so the record can be walked byte by
  // byte in storage order rather than in wire order.
  function automatic check_t calc_check(input logic [REC_W-1:0] rec);
    check_t c;
    c.sum    = '0;
    c.parity = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      c.sum    = c.sum + rec[i*8 +: 8];
      c.parity = c.parity ^ rec[i*8 +: 8];
    end
    return c;
  endfunction

endpackage

// File: rtl/bep_record_fifo.sv
// ---------------------------------------------------------------------------
// bep_record_fifo
// First-word-fall-through record FIFO. Storage, read/write pointers and the
// occupancy count all live here. A push into a full FIFO is accepted only when
// a pop happens on the same edge; a pop when empty is ignored.
// Ports:
//   serial_clock  in   clock
//   reset_n       in   asynchronous active-low reset (storage cleared to zero)
//   push          in   write request
//   push_data     in   record to write
//   pop           in   read request
//   head_data     out  entry at the read pointer (zero until first write)
//   not_empty     out  at least one entry held
//   is_full       out  DEPTH entries held
//   occupancy     out  number of entries held
// ---------------------------------------------------------------------------
module bep_record_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 72
) (
  input  logic                     serial_clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     not_empty,
  output logic                     is_full,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_OCC = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (occ_q != '0);
  assign is_full   = (occ_q == DEPTH_OCC);
  assign occupancy = occ_q;
  assign head_data = mem_q[rd_ptr_q];

  // The pop frees the head slot first, so a full FIFO can still take a push
  // on the same edge.
  assign do_pop  = pop & not_empty;
  assign do_push = push & (~is_full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge serial_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/bep_frame_capture.sv
// ---------------------------------------------------------------------------
// bep_frame_capture
// Downstream of the serial frame decoder. When the decoder raises `full`, the
// three tail bytes are checked against the nine payload bytes, good records
// are queued in a small FWFT FIFO for the host, and the decoder is re-armed by
// a one-cycle low pulse on decoder_clear_n. Bad frames and good frames lost to
// a full FIFO are tallied in saturating counters.
//
// Optional feature macro: BEP_DUP_FILTER_EN
//   When defined, a passing frame identical to the last pushed record is not
//   queued; dup_count counts such frames instead.
//
// Ports:
//   serial_clock     in   clock
//   reset_n          in   asynchronous active-low reset
//   full             in   decoder frame-complete flag, fields stable while high
//   thermostat_id    in   decoded field (32)
//   room_temp        in   decoded field (16)
//   set_temp         in   decoded field (16)
//   state            in   decoded field (8)
//   tail_1/2/3       in   check bytes
//   decoder_clear_n  out  one-cycle low pulse to re-arm the decoder
//   rec_valid        out  FIFO non-empty
//   rec_ready        in   host pop
//   rec_id/room/set/state out  head record
//   occupancy        out  entries held
//   check_err_count  out  frames failing the tail check (saturating)
//   overflow_count   out  good frames dropped on a full FIFO (saturating)
//   dup_count        out  duplicates suppressed (BEP_DUP_FILTER_EN only)
// ---------------------------------------------------------------------------
module bep_frame_capture
  import bep_frame_capture_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                   serial_clock,
  input  logic                   reset_n,
  input  logic                   full,
  input  logic [31:0]            thermostat_id,
  input  logic [15:0]            room_temp,
  input  logic [15:0]            set_temp,
  input  logic [7:0]             state,
  input  logic [7:0]             tail_1,
  input  logic [7:0]             tail_2,
  input  logic [7:0]             tail_3,
  output logic                   decoder_clear_n,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [31:0]            rec_id,
  output logic [15:0]            rec_room,
  output logic [15:0]            rec_set,
  output logic [7:0]             rec_state,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       check_err_count,
  output logic [CNT_W-1:0]       overflow_count
`ifdef BEP_DUP_FILTER_EN
  ,
  output logic [CNT_W-1:0]       dup_count
`endif
);

  fsm_state_e       fsm_q, fsm_d;
  logic             pass_q, pass_d;
  logic [REC_W-1:0] rec_q, rec_d;
  logic             clear_n_q, clear_n_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic [REC_W-1:0] in_rec;
  check_t           in_chk;
  logic             in_pass;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic [REC_W-1:0] head_rec;

  assign in_rec  = {thermostat_id, room_temp, set_temp, state};
  assign in_chk  = calc_check(in_rec);
  assign in_pass = (tail_1 == in_chk.sum) && (tail_2 == in_chk.parity) &&
                   (tail_3 == ~in_chk.sum);

  assign pop = rec_valid & rec_ready;

`ifdef BEP_DUP_FILTER_EN
  logic [REC_W-1:0] last_rec_q, last_rec_d;
  logic             last_valid_q, last_valid_d;
  logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;
  logic             is_dup;

  assign is_dup    = last_valid_q && (last_rec_q == rec_q);
  assign dup_count = dup_cnt_q;
`endif

  // Next-state and counter logic of the capture controller. The registered
  // pass flag and record captured in CHECK are what COMMIT acts on, so the
  // decoder fields only need to stay valid through the CHECK cycle.
  always_comb begin
    fsm_d     = fsm_q;
    pass_d    = pass_q;
    rec_d     = rec_q;
    clear_n_d = 1'b1;
    err_cnt_d = err_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    push      = 1'b0;
`ifdef BEP_DUP_FILTER_EN
    last_rec_d   = last_rec_q;
    last_valid_d = last_valid_q;
    dup_cnt_d    = dup_cnt_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (full) fsm_d = ST_CHECK;
      end
      ST_CHECK: begin
        pass_d = in_pass;
        rec_d  = in_rec;
        fsm_d  = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (!pass_q) begin
          if (~&err_cnt_q) err_cnt_d = err_cnt_q + 1'b1;
`ifdef BEP_DUP_FILTER_EN
        end else if (is_dup) begin
          if (~&dup_cnt_q) dup_cnt_d = dup_cnt_q + 1'b1;
`endif
        end else if (!fifo_full || pop) begin
          push = 1'b1;
`ifdef BEP_DUP_FILTER_EN
          last_rec_d   = rec_q;
          last_valid_d = 1'b1;
`endif
        end else begin
          if (~&ovf_cnt_q) ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
        // Registered low so the pulse covers exactly the CLEAR cycle.
        clear_n_d = 1'b0;
        fsm_d     = ST_CLEAR;
      end
      ST_CLEAR: begin
        fsm_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!full) fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge serial_clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q     <= ST_IDLE;
      pass_q    <= 1'b0;
      rec_q     <= '0;
      clear_n_q <= 1'b1;
      err_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      pass_q    <= pass_d;
      rec_q     <= rec_d;
      clear_n_q <= clear_n_d;
      err_cnt_q <= err_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

`ifdef BEP_DUP_FILTER_EN
  always_ff @(posedge serial_clock or negedge reset_n) begin
    if (!reset_n) begin
      last_rec_q   <= '0;
      last_valid_q <= 1'b0;
      dup_cnt_q    <= '0;
    end else begin
      last_rec_q   <= last_rec_d;
      last_valid_q <= last_valid_d;
      dup_cnt_q    <= dup_cnt_d;
    end
  end
`endif

  bep_record_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .serial_clock (serial_clock),
    .reset_n      (reset_n),
    .push         (push),
    .push_data    (rec_q),
    .pop          (pop),
    .head_data    (head_rec),
    .not_empty    (rec_valid),
    .is_full      (fifo_full),
    .occupancy    (occupancy)
  );

  assign decoder_clear_n = clear_n_q;
  assign rec_id          = head_rec[ID_LSB    +: ID_W];
  assign rec_room        = head_rec[ROOM_LSB  +: ROOM_W];
  assign rec_set         = head_rec[SET_LSB   +: SET_W];
  assign rec_state       = head_rec[STATE_LSB +: STATE_W];
  assign check_err_count = err_cnt_q;
  assign overflow_count  = ovf_cnt_q;

endmodule

// File: tb/tb_bep_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_bep_frame_capture
// Self-checking bench for bep_frame_capture. A queue-based reference model
// tracks FIFO contents and the error/overflow/duplicate counters from the
// tail-check rules; each scenario task drives frames and compares the DUT
// against the model. Define BEP_DUP_FILTER_EN to exercise the duplicate filter.
// ---------------------------------------------------------------------------
module tb_bep_frame_capture;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              serial_clock = 1'b0;
  logic              reset_n      = 1'b0;
  logic              full         = 1'b0;
  logic [31:0]       thermostat_id = '0;
  logic [15:0]       room_temp    = '0;
  logic [15:0]       set_temp     = '0;
  logic [7:0]        state        = '0;
  logic [7:0]        tail_1       = '0;
  logic [7:0]        tail_2       = '0;
  logic [7:0]        tail_3       = '0;
  logic              rec_ready    = 1'b0;
  logic              decoder_clear_n;
  logic              rec_valid;
  logic [31:0]       rec_id;
  logic [15:0]       rec_room;
  logic [15:0]       rec_set;
  logic [7:0]        rec_state;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  check_err_count;
  logic [CNT_W-1:0]  overflow_count;
`ifdef BEP_DUP_FILTER_EN
  logic [CNT_W-1:0]  dup_count;
`endif

  bep_frame_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .serial_clock    (serial_clock),
    .reset_n         (reset_n),
    .full            (full),
    .thermostat_id   (thermostat_id),
    .room_temp       (room_temp),
    .set_temp        (set_temp),
    .state           (state),
    .tail_1          (tail_1),
    .tail_2          (tail_2),
    .tail_3          (tail_3),
    .decoder_clear_n (decoder_clear_n),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .rec_id          (rec_id),
    .rec_room        (rec_room),
    .rec_set         (rec_set),
    .rec_state       (rec_state),
    .occupancy       (occupancy),
    .check_err_count (check_err_count),
    .overflow_count  (overflow_count)
`ifdef BEP_DUP_FILTER_EN
    ,
    .dup_count       (dup_count)
`endif
  );

  always #5 serial_clock = ~serial_clock;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [71:0] mq[$];
  int          exp_err;
  int          exp_ovf;
  int          exp_dup;
  logic [71:0] last_rec;
  bit          last_valid;

  // Observations of the most recent frame
  logic [4:0]  clr_trace;
  logic        valid_mid;

  function automatic void model_reset();
    mq.delete();
    exp_err    = 0;
    exp_ovf    = 0;
    exp_dup    = 0;
    last_rec   = '0;
    last_valid = 0;
  endfunction

  // Good tails computed straight from the payload byte list.
  function automatic void make_tails(input logic [71:0] rec, output logic [7:0] t1,
                                     output logic [7:0] t2, output logic [7:0] t3);
    int         s;
    logic [7:0] x;
    logic [7:0] b;
    s = 0;
    x = 8'h00;
    for (int k = 0; k < 9; k++) begin
      b = rec[71 - 8*k -: 8];
      s = s + int'(b);
      x = x ^ b;
    end
    t1 = 8'(s % 256);
    t2 = x;
    t3 = ~t1;
  endfunction

  function automatic void model_commit(input logic [71:0] rec, input logic [7:0] t1,
                                       input logic [7:0] t2, input logic [7:0] t3,
                                       input bit ready);
    logic [7:0] g1, g2, g3;
    int         was_size;
    bit         popped;
    make_tails(rec, g1, g2, g3);
    was_size = mq.size();
    popped   = ready && (was_size > 0);
    if (popped) void'(mq.pop_front());
    if (!(t1 == g1 && t2 == g2 && t3 == g3)) begin
      if (exp_err < CMAX) exp_err++;
`ifdef BEP_DUP_FILTER_EN
    end else if (last_valid && last_rec == rec) begin
      if (exp_dup < CMAX) exp_dup++;
`endif
    end else if (was_size < DEPTH || popped) begin
      mq.push_back(rec);
      last_rec   = rec;
      last_valid = 1;
    end else begin
      if (exp_ovf < CMAX) exp_ovf++;
    end
  endfunction

  task automatic apply_reset();
    reset_n   = 1'b0;
    full      = 1'b0;
    rec_ready = 1'b0;
    repeat (2) @(posedge serial_clock);
    @(negedge serial_clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Drives one frame through IDLE..WAIT with fixed timing; optionally raises
  // rec_ready only across the COMMIT edge. When preset is set the caller has
  // already placed the fields and full on the wires.
  task automatic run_frame(input logic [71:0] rec, input logic [7:0] t1, input logic [7:0] t2,
                           input logic [7:0] t3, input bit ready_c, input bit preset);
    if (!preset) begin
      @(negedge serial_clock);
      {thermostat_id, room_temp, set_temp, state} = rec;
      tail_1 = t1;
      tail_2 = t2;
      tail_3 = t3;
      full   = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rec_ready = ready_c;
      @(posedge serial_clock);
      @(negedge serial_clock);
      clr_trace[i] = decoder_clear_n;
      if (i == 1) valid_mid = rec_valid;
      if (i == 2) rec_ready = 1'b0;
      if (i == 3) full = 1'b0;
    end
    model_commit(rec, t1, t2, t3, ready_c);
  endtask

  task automatic pop_one();
    @(negedge serial_clock);
    rec_ready = 1'b1;
    @(posedge serial_clock);
    @(negedge serial_clock);
    rec_ready = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  function automatic logic [71:0] rand_rec();
    logic [71:0] r;
    r[71:40] = $urandom;
    r[39:8]  = $urandom;
    r[7:0]   = 8'($urandom);
    return r;
  endfunction

  task automatic test_reset();
    apply_reset();
    compared += 6;
    if (decoder_clear_n !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_clear_n got %b want 1", decoder_clear_n); end
    if (rec_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b want 0", rec_valid); end
    if (occupancy !== '0) begin mismatched++; $display("[TB] FAIL reset_occ got %0d want 0", occupancy); end
    if ({rec_id, rec_room, rec_set, rec_state} !== 72'h0) begin mismatched++; $display("[TB] FAIL reset_rec got %h want 0", {rec_id, rec_room, rec_set, rec_state}); end
    if (check_err_count !== '0) begin mismatched++; $display("[TB] FAIL reset_err got %0d want 0", check_err_count); end
    if (overflow_count !== '0) begin mismatched++; $display("[TB] FAIL reset_ovf got %0d want 0", overflow_count); end
  endtask

  task automatic test_good_frame();
    run_frame({32'h12345678, 16'h00D2, 16'h00E6, 8'h01}, 8'hCD, 8'h3D, 8'h32, 0, 0);
    compared += 5;
    if (clr_trace !== 5'b11011) begin mismatched++; $display("[TB] FAIL good_clear_pulse got %b want 11011", clr_trace); end
    if (valid_mid !== 1'b0) begin mismatched++; $display("[TB] FAIL good_valid_early got %b want 0", valid_mid); end
    if (rec_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL good_valid got %b want 1", rec_valid); end
    if (rec_id !== 32'h12345678) begin mismatched++; $display("[TB] FAIL good_rec_id got %h want 12345678", rec_id); end
    if (occupancy !== OCC_W'(1)) begin mismatched++; $display("[TB] FAIL good_occ got %0d want 1", occupancy); end
  endtask

  task automatic test_bad_tail();
    run_frame({32'h12345678, 16'h00D2, 16'h00E6, 8'h01}, 8'hCD, 8'h3E, 8'h32, 0, 0);
    compared += 3;
    if (clr_trace !== 5'b11011) begin mismatched++; $display("[TB] FAIL bad_clear_pulse got %b want 11011", clr_trace); end
    if (occupancy !== OCC_W'(1)) begin mismatched++; $display("[TB] FAIL bad_occ got %0d want 1", occupancy); end
    if (check_err_count !== CNT_W'(1)) begin mismatched++; $display("[TB] FAIL bad_err got %0d want 1", check_err_count); end
  endtask

  task automatic test_overflow();
    logic [71:0] frames[DEPTH+2];
    logic [7:0]  t1, t2, t3;
    for (int k = 0; k < DEPTH + 2; k++) frames[k] = rand_rec();
    for (int k = 0; k < DEPTH + 2; k++) if (mq.size() > 0) pop_one();
    for (int k = 0; k < DEPTH + 1; k++) begin
      make_tails(frames[k], t1, t2, t3);
      run_frame(frames[k], t1, t2, t3, 0, 0);
    end
    compared += 3;
    if (occupancy !== OCC_W'(DEPTH)) begin mismatched++; $display("[TB] FAIL ovf_occ got %0d want %0d", occupancy, DEPTH); end
    if (overflow_count !== CNT_W'(1)) begin mismatched++; $display("[TB] FAIL ovf_count got %0d want 1", overflow_count); end
    if ({rec_id, rec_room, rec_set, rec_state} !== frames[0]) begin mismatched++; $display("[TB] FAIL ovf_head got %h want %h", {rec_id, rec_room, rec_set, rec_state}, frames[0]); end
    // Full FIFO with a pop on the COMMIT edge: push and pop both happen.
    make_tails(frames[DEPTH+1], t1, t2, t3);
    run_frame(frames[DEPTH+1], t1, t2, t3, 1, 0);
    compared += 3;
    if (occupancy !== OCC_W'(DEPTH)) begin mismatched++; $display("[TB] FAIL pushpop_occ got %0d want %0d", occupancy, DEPTH); end
    if (overflow_count !== CNT_W'(1)) begin mismatched++; $display("[TB] FAIL pushpop_ovf got %0d want 1", overflow_count); end
    if ({rec_id, rec_room, rec_set, rec_state} !== frames[1]) begin mismatched++; $display("[TB] FAIL pushpop_head got %h want %h", {rec_id, rec_room, rec_set, rec_state}, frames[1]); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (mq.size() > 0) begin
        compared++;
        if ({rec_id, rec_room, rec_set, rec_state} !== mq[0]) begin mismatched++; $display("[TB] FAIL drain_head got %h want %h", {rec_id, rec_room, rec_set, rec_state}, mq[0]); end
      end
      pop_one();
    end
    compared += 2;
    if (rec_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_valid got %b want 0", rec_valid); end
    if (occupancy !== '0) begin mismatched++; $display("[TB] FAIL drain_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    logic [71:0] r;
    logic [7:0]  t1, t2, t3;
    r = rand_rec();
    make_tails(r, t1, t2, t3);
    run_frame(r, t1, t2, t3, 0, 0);
    // Start a new frame, then reset while the controller is in CHECK.
    r = rand_rec();
    make_tails(r, t1, t2, t3);
    @(negedge serial_clock);
    {thermostat_id, room_temp, set_temp, state} = r;
    {tail_1, tail_2, tail_3} = {t1, t2, t3};
    full = 1'b1;
    @(posedge serial_clock);
    @(negedge serial_clock);
    reset_n = 1'b0;
    full    = 1'b0;
    #1;
    model_reset();
    compared += 5;
    if (decoder_clear_n !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_clear_n got %b want 1", decoder_clear_n); end
    if (rec_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_valid got %b want 0", rec_valid); end
    if ({rec_id, rec_room, rec_set, rec_state} !== 72'h0) begin mismatched++; $display("[TB] FAIL midrst_rec got %h want 0", {rec_id, rec_room, rec_set, rec_state}); end
    if (check_err_count !== '0) begin mismatched++; $display("[TB] FAIL midrst_err got %0d want 0", check_err_count); end
    if (overflow_count !== '0) begin mismatched++; $display("[TB] FAIL midrst_ovf got %0d want 0", overflow_count); end
    repeat (2) @(posedge serial_clock);
    // full already high on the first edge after reset release.
    r = rand_rec();
    make_tails(r, t1, t2, t3);
    @(negedge serial_clock);
    {thermostat_id, room_temp, set_temp, state} = r;
    {tail_1, tail_2, tail_3} = {t1, t2, t3};
    full = 1'b1;
    @(negedge serial_clock);
    reset_n = 1'b1;
    run_frame(r, t1, t2, t3, 0, 1);
    compared += 3;
    if (clr_trace !== 5'b11011) begin mismatched++; $display("[TB] FAIL postrst_clear_pulse got %b want 11011", clr_trace); end
    if (occupancy !== OCC_W'(1)) begin mismatched++; $display("[TB] FAIL postrst_occ got %0d want 1", occupancy); end
    if ({rec_id, rec_room, rec_set, rec_state} !== r) begin mismatched++; $display("[TB] FAIL postrst_head got %h want %h", {rec_id, rec_room, rec_set, rec_state}, r); end
  endtask

  task automatic test_random();
    logic [71:0] r, prev;
    logic [7:0]  t1, t2, t3;
    bit          have_prev;
    have_prev = 0;
    prev      = '0;
    for (int n = 0; n < 24; n++) begin
      r = (have_prev && $urandom_range(0, 3) == 0) ? prev : rand_rec();
      make_tails(r, t1, t2, t3);
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       t1 = t1 ^ 8'(1 << $urandom_range(0, 7));
          1:       t2 = t2 ^ 8'(1 << $urandom_range(0, 7));
          default: t3 = t3 ^ 8'(1 << $urandom_range(0, 7));
        endcase
      end
      run_frame(r, t1, t2, t3, bit'($urandom_range(0, 1)), 0);
      prev      = r;
      have_prev = 1;
      compared += 5;
      if (clr_trace !== 5'b11011) begin mismatched++; $display("[TB] FAIL rand_clear_pulse[%0d] got %b want 11011", n, clr_trace); end
      if (occupancy !== OCC_W'(mq.size())) begin mismatched++; $display("[TB] FAIL rand_occ[%0d] got %0d want %0d", n, occupancy, mq.size()); end
      if (rec_valid !== (mq.size() > 0)) begin mismatched++; $display("[TB] FAIL rand_valid[%0d] got %b want %b", n, rec_valid, mq.size() > 0); end
      if (check_err_count !== CNT_W'(exp_err)) begin mismatched++; $display("[TB] FAIL rand_err[%0d] got %0d want %0d", n, check_err_count, exp_err); end
      if (overflow_count !== CNT_W'(exp_ovf)) begin mismatched++; $display("[TB] FAIL rand_ovf[%0d] got %0d want %0d", n, overflow_count, exp_ovf); end
`ifdef BEP_DUP_FILTER_EN
      compared++;
      if (dup_count !== CNT_W'(exp_dup)) begin mismatched++; $display("[TB] FAIL rand_dup[%0d] got %0d want %0d", n, dup_count, exp_dup); end
`endif
      if (mq.size() > 0) begin
        compared++;
        if ({rec_id, rec_room, rec_set, rec_state} !== mq[0]) begin mismatched++; $display("[TB] FAIL rand_head[%0d] got %h want %h", n, {rec_id, rec_room, rec_set, rec_state}, mq[0]); end
      end
    end
  endtask

`ifdef BEP_DUP_FILTER_EN
  task automatic test_dup_filter();
    logic [71:0] r;
    logic [7:0]  t1, t2, t3;
    apply_reset();
    r = {32'h12345678, 16'h00D2, 16'h00E6, 8'h01};
    run_frame(r, 8'hCD, 8'h3D, 8'h32, 0, 0);
    run_frame(r, 8'hCD, 8'h3D, 8'h32, 0, 0);
    compared += 2;
    if (occupancy !== OCC_W'(1)) begin mismatched++; $display("[TB] FAIL dup_occ got %0d want 1", occupancy); end
    if (dup_count !== CNT_W'(1)) begin mismatched++; $display("[TB] FAIL dup_count got %0d want 1", dup_count); end
    r = {32'h12345678, 16'h00D3, 16'h00E6, 8'h01};
    make_tails(r, t1, t2, t3);
    run_frame(r, t1, t2, t3, 0, 0);
    compared += 2;
    if (occupancy !== OCC_W'(2)) begin mismatched++; $display("[TB] FAIL dup_new_occ got %0d want 2", occupancy); end
    if (dup_count !== CNT_W'(1)) begin mismatched++; $display("[TB] FAIL dup_new_count got %0d want 1", dup_count); end
  endtask
`endif

  task automatic test_saturation();
    logic [71:0] r;
    logic [7:0]  t1, t2, t3;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      r = rand_rec();
      make_tails(r, t1, t2, t3);
      run_frame(r, t1, ~t2, t3, 0, 0);
    end
    compared += 2;
    if (check_err_count !== 8'hFF) begin mismatched++; $display("[TB] FAIL sat_err got %0d want 255", check_err_count); end
    if (occupancy !== '0) begin mismatched++; $display("[TB] FAIL sat_occ got %0d want 0", occupancy); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_good_frame();
    test_bad_tail();
    test_overflow();
    test_drain();
    test_reset_mid();
    test_random();
`ifdef BEP_DUP_FILTER_EN
    test_dup_filter();
`endif
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
